// File: rtl/ysyx_22041071_mul_iter.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, valid/ready
// on both request and result sides, flush cancels the operation in flight.
module ysyx_22041071_mul_iter #(
   parameter int unsigned XLEN  = 64,
   parameter int unsigned W_LEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            mul_valid,
   output logic            mul_ready,
   input  logic            mulw,
   input  logic [1:0]      mul_signed,
   input  logic [XLEN-1:0] mul_1,
   input  logic [XLEN-1:0] mul_2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result_h,
   output logic [XLEN-1:0] result_l
);

   localparam int unsigned AW     = 2 * XLEN + 2;   // accumulator / multiplicand width
   localparam int unsigned MW     = XLEN + 3;       // multiplier: 2 extension bits + appended 0
   localparam int unsigned N_FULL = XLEN / 2 + 1;
   localparam int unsigned N_WORD = W_LEN / 2 + 1;
   localparam int unsigned CW     = $clog2(N_FULL);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   mcand;
   logic [MW-1:0]   mplier;
   logic [CW-1:0]   cnt;

   logic            sign_1;
   logic            sign_2;
   logic            reserved;
   logic [AW-1:0]   op1_ext;
   logic [XLEN+1:0] op2_ext;
   logic [AW-1:0]   mcand_x2;
   logic [AW-1:0]   digit;
   logic [AW-1:0]   acc_next;

   // Operand extension per mode; the reserved mode loads a zero multiplicand
   always_comb begin
      sign_1   = mul_signed[1];
      sign_2   = (mul_signed == 2'b11);
      reserved = (mul_signed == 2'b01);
      if (mulw) begin
         op1_ext = {{(AW - W_LEN){sign_1 & mul_1[W_LEN-1]}}, mul_1[W_LEN-1:0]};
         op2_ext = {{(XLEN + 2 - W_LEN){sign_2 & mul_2[W_LEN-1]}}, mul_2[W_LEN-1:0]};
      end else begin
         op1_ext = {{(AW - XLEN){sign_1 & mul_1[XLEN-1]}}, mul_1};
         op2_ext = {{2{sign_2 & mul_2[XLEN-1]}}, mul_2};
      end
      if (reserved) begin
         op1_ext = '0;
      end
   end

   // Booth digit select {0, +-X, +-2X} from the multiplier's low 3 bits
   always_comb begin
      mcand_x2 = {mcand[AW-2:0], 1'b0};
      digit    = '0;
      unique case (mplier[2:0])
         3'b001, 3'b010: digit = mcand;
         3'b011:         digit = mcand_x2;
         3'b100:         digit = AW'(0) - mcand_x2;
         3'b101, 3'b110: digit = AW'(0) - mcand;
         default:        digit = '0;
      endcase
      acc_next = acc + digit;
   end

   // Control FSM and shift-add datapath; flush outranks every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mul_ready <= 1'b1;
         out_valid <= 1'b0;
         result_h  <= '0;
         result_l  <= '0;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
      end else if (flush) begin
         state     <= IDLE;
         mul_ready <= 1'b1;
         out_valid <= 1'b0;
         acc       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mul_valid) begin
                  state     <= BUSY;
                  mul_ready <= 1'b0;
                  acc       <= '0;
                  mcand     <= op1_ext;
                  mplier    <= {op2_ext, 1'b0};
                  cnt       <= mulw ? CW'(N_WORD - 1) : CW'(N_FULL - 1);
               end
            end
            BUSY: begin
               acc    <= acc_next;
               mcand  <= {mcand[AW-3:0], 2'b00};
               mplier <= {{2{mplier[MW-1]}}, mplier[MW-1:2]};
               if (cnt == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result_h  <= acc_next[2*XLEN-1:XLEN];
                  result_l  <= acc_next[XLEN-1:0];
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  mul_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               mul_ready <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22041071_mul_iter.sv
// Directed bench for the iterative Booth multiplier with a result scoreboard.
module tb_ysyx_22041071_mul_iter;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned W_LEN = 32;
   localparam int LAT_FULL = 33;
   localparam int LAT_WORD = 17;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic            mul_valid;
   logic            mul_ready;
   logic            mulw;
   logic [1:0]      mul_signed;
   logic [XLEN-1:0] mul_1;
   logic [XLEN-1:0] mul_2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result_h;
   logic [XLEN-1:0] result_l;

   int checks   = 0;
   int failures = 0;
   logic [127:0] sb[$];
   logic [127:0] last_res;

   ysyx_22041071_mul_iter #(.XLEN(XLEN), .W_LEN(W_LEN)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .mul_valid(mul_valid), .mul_ready(mul_ready),
      .mulw(mulw), .mul_signed(mul_signed),
      .mul_1(mul_1), .mul_2(mul_2),
      .out_valid(out_valid), .out_ready(out_ready),
      .result_h(result_h), .result_l(result_l)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [1:0] s, input logic w);
      logic [127:0] ea;
      logic [127:0] eb;
      logic sa;
      logic sbg;
      sa  = s[1];
      sbg = (s == 2'b11);
      if (s == 2'b01) return '0;
      if (w) begin
         ea = sa  ? {{96{a[31]}}, a[31:0]} : {96'b0, a[31:0]};
         eb = sbg ? {{96{b[31]}}, b[31:0]} : {96'b0, b[31:0]};
      end else begin
         ea = sa  ? {{64{a[63]}}, a} : {64'b0, a};
         eb = sbg ? {{64{b[63]}}, b} : {64'b0, b};
      end
      return ea * eb;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] s, input logic w);
      @(negedge clk);
      mul_1 = a; mul_2 = b; mul_signed = s; mulw = w; mul_valid = 1'b1;
      check("ready_at_request", 128'(mul_ready), 128'(1));
      @(posedge clk);
      #1;
      mul_valid  = 1'b0;
      mul_1      = {$urandom, $urandom};
      mul_2      = {$urandom, $urandom};
      mul_signed = 2'($urandom_range(3));
      mulw       = 1'($urandom_range(1));
   endtask

   task automatic wait_done(output int cyc, output logic ready_low);
      cyc = 0;
      ready_low = 1'b1;
      do begin
         @(posedge clk);
         #1;
         cyc++;
         if (!out_valid && mul_ready) ready_low = 1'b0;
      end while (!out_valid && cyc < 200);
      check("out_valid_timeout", 128'(out_valid), 128'(1));
   endtask

   task automatic check_result(input string tag);
      logic [127:0] exp;
      if (sb.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 128'(0), 128'(1));
      end else begin
         exp = sb.pop_front();
         last_res = exp;
         check({tag, "_h"}, 128'(result_h), 128'(exp[127:64]));
         check({tag, "_l"}, 128'(result_l), 128'(exp[63:0]));
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("consume_out_valid", 128'(out_valid), 128'(0));
      check("consume_mul_ready", 128'(mul_ready), 128'(1));
   endtask

   task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] s, input logic w,
                         input logic [127:0] exp, input int lat);
      int cyc;
      logic rl;
      sb.push_back(exp);
      start_op(a, b, s, w);
      wait_done(cyc, rl);
      check({tag, "_latency"}, 128'(cyc), 128'(lat));
      check({tag, "_ready_low_busy"}, 128'(rl), 128'(1));
      check_result(tag);
      consume();
   endtask

   initial begin
      int cyc;
      logic rl;
      logic [63:0] ra;
      logic [63:0] rb;
      logic [1:0]  rs;
      logic        rw;
      logic        seen;

      rst = 1'b1; flush = 1'b0; mul_valid = 1'b0; out_ready = 1'b0;
      mulw = 1'b0; mul_signed = 2'b00; mul_1 = '0; mul_2 = '0;
      last_res = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_mul_ready", 128'(mul_ready), 128'(1));
      check("reset_out_valid", 128'(out_valid), 128'(0));
      check("reset_result_h", 128'(result_h), 128'(0));
      check("reset_result_l", 128'(result_l), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      run_op("uu_max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0,
             {64'hFFFF_FFFF_FFFF_FFFE, 64'h1}, LAT_FULL);
      run_op("ss_minsq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0,
             {64'h4000_0000_0000_0000, 64'h0}, LAT_FULL);
      run_op("ss_m1m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
             {64'h0, 64'h1}, LAT_FULL);
      run_op("su_m2x3", 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 2'b10, 1'b0,
             {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA}, LAT_FULL);
      run_op("w_ss", 64'hDEAD_BEEF_FFFF_FFFF, 64'd7, 2'b11, 1'b1,
             {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9}, LAT_WORD);
      run_op("w_uu", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1,
             {64'h0, 64'hFFFF_FFFE_0000_0001}, LAT_WORD);
      run_op("reserved", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2'b01, 1'b0,
             128'h0, LAT_FULL);

      // Randomised operands against the reference model
      for (int i = 0; i < 6; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rs = (i % 3 == 0) ? 2'b11 : ((i % 3 == 1) ? 2'b10 : 2'b00);
         rw = (i >= 3);
         run_op("rand", ra, rb, rs, rw, model(ra, rb, rs, rw), rw ? LAT_WORD : LAT_FULL);
      end

      // Flush on the 10th BUSY cycle
      start_op(64'd1000, 64'd2000, 2'b00, 1'b0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_mul_ready", 128'(mul_ready), 128'(1));
      check("flush_out_valid", 128'(out_valid), 128'(0));
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("flush_no_valid", 128'(seen), 128'(0));
      check("flush_keep_h", 128'(result_h), 128'(last_res[127:64]));
      check("flush_keep_l", 128'(result_l), 128'(last_res[63:0]));
      run_op("after_flush", 64'd3, 64'd5, 2'b00, 1'b0, {64'h0, 64'd15}, LAT_FULL);

      // Hold result in DONE with out_ready low while mul_valid is asserted
      sb.push_back(model(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0));
      start_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b11, 1'b0);
      wait_done(cyc, rl);
      check("hold_latency", 128'(cyc), 128'(LAT_FULL));
      check_result("hold");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         mul_valid = 1'b1;
         mul_1 = {$urandom, $urandom};
         @(posedge clk);
         #1;
         check("hold_out_valid", 128'(out_valid), 128'(1));
         check("hold_mul_ready", 128'(mul_ready), 128'(0));
         check("hold_h", 128'(result_h), 128'(last_res[127:64]));
         check("hold_l", 128'(result_l), 128'(last_res[63:0]));
      end
      @(negedge clk);
      mul_valid = 1'b0;
      consume();

      // flush together with mul_valid in IDLE must not start an operation
      @(negedge clk);
      mul_valid = 1'b1; flush = 1'b1; mul_1 = 64'd9; mul_2 = 64'd9; mul_signed = 2'b00; mulw = 1'b0;
      @(posedge clk);
      #1;
      mul_valid = 1'b0; flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (out_valid || !mul_ready) seen = 1'b1;
      end
      check("flush_idle_not_accepted", 128'(seen), 128'(0));

      // Flush in DONE with out_ready high: result registers hold
      sb.push_back({64'h0, 64'h12340});
      start_op(64'h1234, 64'h10, 2'b00, 1'b0);
      wait_done(cyc, rl);
      check_result("done_flush");
      @(negedge clk);
      flush = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0; out_ready = 1'b0;
      check("done_flush_out_valid", 128'(out_valid), 128'(0));
      check("done_flush_mul_ready", 128'(mul_ready), 128'(1));
      check("done_flush_keep_l", 128'(result_l), 128'(64'h12340));

      // Reset mid-BUSY returns to reset values
      start_op(64'd77, 64'd88, 2'b00, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy_mul_ready", 128'(mul_ready), 128'(1));
      check("rst_busy_out_valid", 128'(out_valid), 128'(0));
      check("rst_busy_result_h", 128'(result_h), 128'(0));
      check("rst_busy_result_l", 128'(result_l), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
